phase_fold_accumulator: RTL

//  Parametrised pulse-folding engine. Detects rising edges on an async pulse input and tracks

---
 rtl/fold_pkg.sv | 22 ++
 rtl/fold_profile_ram.sv | 27 ++
 rtl/phase_fold_accumulator.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fold_pkg.sv
// Shared types and helpers for the phase-folding profile engine.
package fold_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ARM,
    S_FOLD,
    S_DRAIN,
    S_READ
  } fold_state_e;

  function automatic int unsigned num_bins(input int unsigned bin_bits);
    return 32'd1 << bin_bits;
  endfunction

  // Saturation ceiling of a cnt_w-bit bin counter.
  function automatic logic [31:0] cnt_max(input int unsigned cnt_w);
    return (cnt_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt_w) - 32'd1);
  endfunction

endpackage

// File: rtl/fold_profile_ram.sv
// Profile storage: one write port, one synchronous read port (1-cycle latency, read-first).
module fold_profile_ram
  import fold_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = int'(num_bins(ADDR_W));

  logic [DATA_W-1:0] mem [DEPTH];

  // A read colliding with a write to the same address returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/phase_fold_accumulator.sv
// Pulse-folding engine: edge detect, divider-free phase tracking, per-bin hit
// counting through a read-modify-write pipe, and a valid/ready profile readout.
module phase_fold_accumulator
  import fold_pkg::*;
#(
  parameter int BIN_BITS = 10,
  parameter int CNT_W    = 16,
  parameter int TIME_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pulse_in,
  input  logic [TIME_W-1:0]   period,
  input  logic [TIME_W-1:0]   epoch,
  input  logic                cmd_clear,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_read,
  output logic                busy,
  output logic                folding,
  output logic                cfg_err,
  output logic                sat,
  output logic [BIN_BITS-1:0] cur_bin,
  output logic [31:0]         event_count,
  output logic                prof_valid,
  input  logic                prof_ready,
  output logic [BIN_BITS-1:0] prof_bin,
  output logic [CNT_W-1:0]    prof_data,
  output logic                prof_last,
  output logic                peak_valid,
  output logic [BIN_BITS-1:0] peak_bin,
  output logic [CNT_W-1:0]    peak_value
);

  localparam int                  NUM_BINS   = int'(num_bins(BIN_BITS));
  localparam logic [CNT_W-1:0]    CNT_MAX    = CNT_W'(cnt_max(CNT_W));
  localparam logic [BIN_BITS-1:0] LAST_BIN   = {BIN_BITS{1'b1}};
  localparam logic [TIME_W:0]     BIN_STEP   = (TIME_W+1)'(NUM_BINS);
  localparam logic [TIME_W-1:0]   MIN_PERIOD = TIME_W'(NUM_BINS);

  fold_state_e state, state_nx;

  logic                sync1, sync2, prev;
  logic                pulse_edge, hit;
  logic                in_idle, clear_go, start_go, start_bad, read_go, xfer;
  logic [TIME_W-1:0]   period_q, arm_cnt, acc;
  logic [TIME_W:0]     step_sum, step_wrap;
  logic [BIN_BITS-1:0] bin, clr_idx, rd_idx;
  logic                s1_valid, fwd_valid;
  logic [BIN_BITS-1:0] s1_bin, fwd_bin;
  logic [CNT_W-1:0]    fwd_data, rmw_old, rmw_new;
  logic                ram_we, ram_re;
  logic [BIN_BITS-1:0] ram_waddr, ram_raddr;
  logic [CNT_W-1:0]    ram_wdata, ram_rdata;

  assign in_idle    = (state == S_IDLE);
  assign clear_go   = in_idle & cmd_clear;
  assign start_go   = in_idle & ~cmd_clear & cmd_start & (period >= MIN_PERIOD);
  assign start_bad  = in_idle & ~cmd_clear & cmd_start & (period < MIN_PERIOD);
  assign read_go    = in_idle & ~cmd_clear & ~cmd_start & cmd_read;
  assign xfer       = prof_valid & prof_ready;
  assign pulse_edge = sync2 & ~prev;
  // Edges coinciding with the stop request are deliberately not counted.
  assign hit        = pulse_edge & (state == S_FOLD) & ~cmd_stop;

  assign step_sum  = {1'b0, acc} + BIN_STEP;
  assign step_wrap = step_sum - {1'b0, period_q};

  assign cur_bin   = folding ? bin : '0;
  assign prof_bin  = rd_idx;
  assign prof_data = prof_valid ? ram_rdata : '0;
  assign prof_last = prof_valid & (rd_idx == LAST_BIN);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_clear)     state_nx = S_CLEAR;
        else if (start_go) state_nx = S_ARM;
        else if (read_go)  state_nx = S_READ;
      end
      S_CLEAR: if (clr_idx == LAST_BIN) state_nx = S_IDLE;
      S_ARM: begin
        if (cmd_stop)           state_nx = S_IDLE;
        else if (arm_cnt == '0) state_nx = S_FOLD;
      end
      S_FOLD:  if (cmd_stop) state_nx = S_DRAIN;
      S_DRAIN: if (!s1_valid) state_nx = S_IDLE;
      S_READ:  if (xfer && (rd_idx == LAST_BIN)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      folding <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx != S_IDLE);
      folding <= (state_nx == S_FOLD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Phase advances by NUM_BINS/period bins per cycle without a divider:
  // acc holds the fractional remainder scaled by period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_idx     <= '0;
      period_q    <= '0;
      arm_cnt     <= '0;
      acc         <= '0;
      bin         <= '0;
      cfg_err     <= 1'b0;
      sat         <= 1'b0;
      event_count <= '0;
    end else begin
      if (clear_go) begin
        clr_idx     <= '0;
        cfg_err     <= 1'b0;
        sat         <= 1'b0;
        event_count <= '0;
      end
      if (state == S_CLEAR) clr_idx <= clr_idx + 1'b1;
      if (start_bad) cfg_err <= 1'b1;
      if (start_go) begin
        period_q <= period;
        arm_cnt  <= epoch;
        acc      <= '0;
        bin      <= '0;
        cfg_err  <= 1'b0;
      end
      if (state == S_ARM && arm_cnt != '0) arm_cnt <= arm_cnt - 1'b1;
      if (state == S_FOLD) begin
        if (step_sum >= {1'b0, period_q}) begin
          acc <= step_wrap[TIME_W-1:0];
          bin <= bin + 1'b1;
        end else begin
          acc <= step_sum[TIME_W-1:0];
        end
      end
      if (hit) event_count <= event_count + 32'd1;
      if (s1_valid && rmw_new == CNT_MAX) sat <= 1'b1;
    end
  end

  // The word written last cycle is not yet visible to a read issued in that
  // same cycle, so it is forwarded when the next update targets the same bin.
  assign rmw_old = (fwd_valid && fwd_bin == s1_bin) ? fwd_data : ram_rdata;
  assign rmw_new = (rmw_old == CNT_MAX) ? CNT_MAX : rmw_old + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_bin    <= '0;
      fwd_valid <= 1'b0;
      fwd_bin   <= '0;
      fwd_data  <= '0;
    end else begin
      s1_valid  <= hit;
      s1_bin    <= bin;
      fwd_valid <= s1_valid;
      fwd_bin   <= s1_bin;
      fwd_data  <= rmw_new;
    end
  end

  always_comb begin
    ram_we    = s1_valid;
    ram_waddr = s1_bin;
    ram_wdata = rmw_new;
    if (state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_idx;
      ram_wdata = '0;
    end
  end

  // Readout keeps the RAM address on the beat being offered and only steps
  // it on a transfer, so the RAM output register itself holds the data stable.
  always_comb begin
    ram_re    = 1'b0;
    ram_raddr = bin;
    if (state == S_FOLD) begin
      ram_re    = hit;
      ram_raddr = bin;
    end else if (read_go) begin
      ram_re    = 1'b1;
      ram_raddr = '0;
    end else if (state == S_READ) begin
      ram_re    = 1'b1;
      ram_raddr = xfer ? rd_idx + 1'b1 : rd_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prof_valid <= 1'b0;
      rd_idx     <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_value <= '0;
    end else begin
      if (clear_go || start_go) peak_valid <= 1'b0;
      if (read_go) begin
        prof_valid <= 1'b1;
        rd_idx     <= '0;
        peak_valid <= 1'b0;
        peak_bin   <= '0;
        peak_value <= '0;
      end else if (state == S_READ && xfer) begin
        if (prof_data > peak_value) begin
          peak_value <= prof_data;
          peak_bin   <= rd_idx;
        end
        if (rd_idx == LAST_BIN) begin
          prof_valid <= 1'b0;
          rd_idx     <= '0;
          peak_valid <= 1'b1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

  fold_profile_ram #(
    .ADDR_W (BIN_BITS),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule
